// File: rtl/mult_div_sequencer.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_SIGNED_EN to make funct 0x18/0x1A signed (magnitude iteration plus result negation).
module mult_div_sequencer #(
  parameter int          DATA_W = 32,
  parameter logic [5:0]  F_MULT = 6'h18,
  parameter logic [5:0]  F_DIV  = 6'h1A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] F_MULTU = F_MULT + 6'd1;
  localparam logic [5:0] F_DIVU  = F_DIV + 6'd1;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_op;
  logic                r_is_div;
  logic                r_b_zero;
  logic                r_busy;
  logic                r_done;
  logic                r_div_zero;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
`ifdef MDU_SIGNED_EN
  logic                r_neg_q;
  logic                r_neg_r;
`endif

  logic                w_is_mul;
  logic                w_is_div;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_div_shift;
  logic [DATA_W:0]     w_div_trial;
  logic [2*DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;
`ifdef MDU_SIGNED_EN
  logic                w_signed;
  logic                w_a_neg;
  logic                w_b_neg;
`endif

  assign w_is_mul = (funct == F_MULT) || (funct == F_MULTU);
  assign w_is_div = (funct == F_DIV)  || (funct == F_DIVU);

`ifdef MDU_SIGNED_EN
  assign w_signed = (funct == F_MULT) || (funct == F_DIV);
  assign w_a_neg  = w_signed & a[DATA_W-1];
  assign w_b_neg  = w_signed & b[DATA_W-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
`endif

  // Both algorithms share one 2*DATA_W register: upper half is the partial
  // product / remainder, lower half the multiplier / dividend-turned-quotient.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_op} : '0);
    w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
    w_div_trial = w_div_shift - {1'b0, r_op};
    w_acc_next  = r_acc;
    if (r_state == S_MUL) begin
      w_acc_next = {w_mul_sum, r_acc[DATA_W-1:1]};
    end else if (r_state == S_DIV) begin
      if (w_div_trial[DATA_W])
        w_acc_next = {w_div_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
      else
        w_acc_next = {w_div_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    w_res_hi = r_acc[2*DATA_W-1:DATA_W];
    w_res_lo = r_acc[DATA_W-1:0];
`ifdef MDU_SIGNED_EN
    if (!r_is_div) begin
      if (r_neg_q) {w_res_hi, w_res_lo} = ~r_acc + 1'b1;
    end else begin
      if (r_neg_q) w_res_lo = ~r_acc[DATA_W-1:0] + 1'b1;
      if (r_neg_r) w_res_hi = ~r_acc[2*DATA_W-1:DATA_W] + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_op       <= '0;
      r_is_div   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MDU_SIGNED_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (w_is_mul || w_is_div)) begin
            r_state  <= w_is_mul ? S_MUL : S_DIV;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_is_div <= w_is_div;
            r_b_zero <= (b == '0);
            r_op     <= w_is_mul ? w_a_mag : w_b_mag;
            r_acc    <= {{DATA_W{1'b0}}, (w_is_mul ? w_b_mag : w_a_mag)};
`ifdef MDU_SIGNED_EN
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
`endif
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_done     <= 1'b1;
            r_div_zero <= r_is_div & r_b_zero;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed operations, expected HI/LO queued at issue.
module tb_mult_div_sequencer;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  mult_div_sequencer #(.DATA_W(DATA_W), .F_MULT(6'h18), .F_DIV(6'h1A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
      end
    end
  end

  // Presents a start at the current negedge; returns one cycle after the accepting edge.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] fv);
    a = av; b = bv; funct = fv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] fv,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int n;
    sb.push_back('{hi: ehi, lo: elo, dz: edz});
    launch(av, bv, fv);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(DATA_W + 2));
    chk("busy_in_done_cycle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd10, 32'd10, 6'h18, 32'd0, 32'd100, 1'b0);
    @(negedge clk);
    run_op(32'd100, 32'd7, 6'h1A, 32'd2, 32'd14, 1'b0);
    run_op(32'd10, 32'd10, 6'h1A, 32'd0, 32'd1, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 6'h19, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(32'h12345678, 32'd0, 6'h1B, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);

    // flush mid-multiply; a second start while busy must be ignored
    base = done_cnt;
    launch(32'd3, 32'd5, 6'h19);
    repeat (3) @(negedge clk);
    launch(32'd7, 32'd9, 6'h18);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", {63'd0, busy}, 64'd0);
    chk("hilo_after_flush", {hi, lo}, {32'h12345678, 32'hFFFFFFFF});
    repeat (40) @(negedge clk);
    chk("no_done_after_flush", 64'(done_cnt), 64'(base));
    chk("idle_after_flush", {63'd0, busy}, 64'd0);

    start = 1'b1; funct = 6'h10;
    @(negedge clk);
    start = 1'b0;
    chk("invalid_funct_ignored", {63'd0, busy}, 64'd0);

    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, {32'hDEADBEEF, 32'hFFFFFFFF});
    lo_we = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});

    // start wins over a simultaneous mthi, and mthi is ignored while busy
    sb.push_back('{hi: 32'd0, lo: 32'd56, dz: 1'b0});
    hi_we = 1'b1; wdata = 32'h11111111;
    launch(32'd8, 32'd7, 6'h19);
    wdata = 32'h22222222;
    @(negedge clk);
    hi_we = 1'b0;
    chk("hi_we_dropped_and_busy", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});
    base = 0;
    while (!done && base < 100) begin
      @(negedge clk);
      base++;
    end
    chk("busy_op_completed", {63'd0, done}, 64'd1);
    @(negedge clk);

`ifdef MDU_SIGNED_EN
    run_op(32'hFFFFFFFA, 32'd7, 6'h18, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 6'h1A, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 6'h1B, 32'd1, 32'h7FFFFFFC, 1'b0);
`else
    run_op(32'hFFFFFFFA, 32'd7, 6'h18, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 6'h1A, 32'd1, 32'h7FFFFFFC, 1'b0);
`endif
    @(negedge clk);

    // asynchronous reset mid-divide
    launch(32'h12345678, 32'd3, 6'h1B);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_reset", {62'd0, busy, done}, 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Multi-cycle multiply/divide unit beside control_alu in the MIPS datapath.
- Takes mult/div funct codes from the R-type decode and runs an iterative shift-add multiply or restoring divide over DATA_W cycles.
- Holds the results in architectural HI/LO registers and supplies the busy/done handshake the pipeline control uses to stall mfhi/mflo.
- Supports mthi/mtlo writes and a flush for exceptions.

Parameters:
- DATA_W, 32: operand width and HI/LO width; iteration count equals DATA_W.
- F_MULT, 6'h18: funct code for mult.
- F_DIV, 6'h1A: funct code for div.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- funct  in  6  operation select; valid codes are 0x18, 0x19, 0x1A, 0x1B.
- a  in  DATA_W  rs operand; multiplicand or dividend.
- b  in  DATA_W  rt operand; multiplier or divisor.
- flush  in  1  synchronous abort of an in-flight operation.
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  DATA_W  mthi/mtlo data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  one-cycle pulse, coincident with done, when a divide had b==0.
- hi  out  DATA_W  HI register (product upper half / remainder).
- lo  out  DATA_W  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, active-low; clock is clk, reset is rst_n): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; iteration counter=0. Reset asserted mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 with funct 0x18/0x19 -> MUL; with 0x1A/0x1B -> DIV.
  - On the accepting edge, latch a and b, clear the accumulator/remainder, counter=0, busy=1.
  - start=1 with any other funct is ignored; busy stays 0.
- MUL: one shift-add step per cycle on a 2*DATA_W accumulator. After DATA_W steps -> FIN.
- DIV: one restoring step per cycle (shift remainder left, trial-subtract divisor, set quotient bit). After DATA_W steps -> FIN.
- FIN (one cycle):
  - Write hi and lo, apply sign correction if enabled, pulse done=1, drop busy to 0 at the next edge, return to IDLE.
- Latency: if start is accepted at edge 0, hi/lo are valid and done=1 during the cycle following edge DATA_W+1 (33 for the default). This latency is fixed and independent of operand values.
- Back-to-back: a start presented in the done cycle is accepted; there is no dead cycle.
- start while busy: ignored, no queuing.
- Divide by zero: lo=all ones, hi=dividend (the natural restoring result), div_zero=1 with done.
- flush: in MUL/DIV/FIN, flush returns the unit to IDLE at the next edge. hi and lo are unchanged, and done and div_zero are not pulsed. flush in IDLE has no effect.
- hi_we/lo_we: honoured only in IDLE and load wdata at the edge. They are ignored while busy.
- start accepted in the same cycle as hi_we/lo_we: start wins and the write is dropped.
- Width rules: mult gives the full 2*DATA_W product, with hi = upper half and lo = lower half. div gives lo = quotient and hi = remainder. Nothing is truncated.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - 0x18/0x1A are signed. Iterate on operand magnitudes, then negate results in FIN: product if signs differ; quotient if signs differ; remainder takes the dividend's sign.
  - 0x19/0x1B are unsigned.
  - Latency is unchanged.
- Undefined: all four funct codes are treated as unsigned and no negation logic is built.

Test Plan:
- a=10, b=10, funct=0x18, start pulse -> busy for 33 cycles, then done=1, hi=0, lo=100.
- a=100, b=7, funct=0x1A -> lo=14, hi=2, div_zero=0. Next: a=10, b=10, div issued in the done cycle -> accepted, lo=1, hi=0.
- a=0x12345678, b=0, funct=0x1B -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 together with done.
- Start a mult, pulse start again at cycle 5 with different operands, then assert flush at cycle 10 -> second start ignored, done never pulses, hi/lo keep their prior values, busy=0 after the flush edge.
- wdata=0xDEADBEEF with hi_we in IDLE -> hi=0xDEADBEEF. hi_we during busy -> no change. rst_n low mid-divide -> busy=0 and hi=lo=0 immediately, without waiting for a clock edge.
- With MDU_SIGNED_EN:
  - a=-6, b=7, 0x18 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
  - a=-7, b=2, 0x1A -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Same div without the macro -> unsigned result lo=0x7FFFFFFC, hi=1.
